out_serializer: RTL
===================

OUT_SERIALIZER -- requirements
Module: out_serializer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..255.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: byte entries in the output queue; legal values are powers of two, 2..16.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port i_nReset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port i_data, input, 8 bits: byte from the CPU bus, sampled when i_wrOut=1.
REQ-006 Port i_wrOut, input, 1 bit: write strobe from the control unit; each high cycle is one write.
REQ-007 Port o_tx, output, 1 bit: serial line, 8N1 format, idle high.
REQ-008 Port o_full, output, 1 bit: queue holds FIFO_DEPTH bytes.
REQ-009 Port o_empty, output, 1 bit: queue holds 0 bytes.
REQ-010 Port o_busy, output, 1 bit: transmitter not in IDLE.
REQ-011 Port o_overflow, output, 1 bit: sticky flag, a write was dropped.

Function
REQ-012 Queue: circular FIFO with read/write pointers of log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH, plus a count of log2(FIFO_DEPTH)+1 bits.
REQ-013 Write: i_wrOut=1 with o_full=0 SHALL store i_data at the write pointer and advance it at that edge.
REQ-014 Full write: i_wrOut=1 with o_full=1 SHALL drop the byte, leave the queue unchanged, and set o_overflow, even if a pop occurs in the same cycle.
REQ-015 o_full, o_empty and o_overflow SHALL be registered, updated on the same edge as the count, with no combinational path from i_wrOut.
REQ-016 Simultaneous push and pop SHALL leave the count unchanged and advance both pointers.
REQ-017 The transmitter FSM SHALL have the states IDLE, START, DATA and STOP, plus an 8-bit shift register, a bit-time counter and a 3-bit bit index.
REQ-018 IDLE: o_tx=1; if the queue is non-empty, pop the head into the shift register, clear the counters and go to START.
REQ-019 START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-020 DATA: o_tx = shift register bit 0 (LSB first); the register shifts right every CLKS_PER_BIT cycles; after 8 bits go to STOP.
REQ-021 STOP: o_tx=1 for CLKS_PER_BIT cycles; at the end, if the queue is non-empty, pop the next byte and go directly to START with no idle gap; otherwise go to IDLE.
REQ-022 o_tx SHALL be driven from a register and be glitch-free.
REQ-023 Latency: with the queue empty and the FSM in IDLE, a write captured at edge n SHALL drive o_tx low from edge n+1.
REQ-024 One frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-025 Writes during a frame SHALL be queued and SHALL NOT disturb the frame in progress.
REQ-026 o_busy SHALL be 1 in START, DATA and STOP.

Reset
REQ-027 Asserting i_nReset low SHALL immediately set: o_tx=1, o_empty=1, o_full=0, o_busy=0, o_overflow=0, FSM=IDLE, count and pointers 0, shift register 0x00.
REQ-028 A reset mid-frame SHALL abort the frame and discard all queued bytes; o_tx SHALL go high without waiting for a clock.
REQ-029 After i_nReset deasserts, the first rising edge SHALL act on normal inputs.
REQ-030 o_overflow SHALL clear only on reset.

Verification
REQ-031 CLKS_PER_BIT=4; write 0xA5 once -> o_tx holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 total), o_busy=1 throughout, then IDLE with o_tx=1.
REQ-032 Write 0x01 and 0x80 on consecutive cycles -> two back-to-back 40-cycle frames with no gap between the first stop bit and the second start bit; o_empty=1 after the second pop.
REQ-033 FIFO_DEPTH=4, FSM busy; 5 writes 0x10..0x14 on consecutive cycles -> the first pop occurs before the writes, so 0x10..0x13 are queued; o_full=1 after the 4th; 0x14 dropped; o_overflow=1; bytes transmitted in order 0x10..0x13.
REQ-034 Queue full while a STOP-end pop and a write coincide -> the write is dropped, o_overflow=1, count goes from 4 to 3.
REQ-035 Assert i_nReset low asynchronously in the middle of DATA -> o_tx=1 and o_empty=1 before the next edge; after release, no residual frame is transmitted.
REQ-036 Pointer wrap: 3*FIFO_DEPTH single bytes 0x00..0x0B written with gaps -> all transmitted in order, o_overflow stays 0.

Source files
------------

// File: rtl/out_serializer_if.sv
// Byte-write / serial-status bundle between the CPU-side control unit and
// the output serializer.
interface out_serializer_if;
    logic [7:0] i_data;
    logic       i_wrOut;
    logic       o_tx;
    logic       o_full;
    logic       o_empty;
    logic       o_busy;
    logic       o_overflow;

    // Control-unit side: drives bytes and write strobes, observes status.
    modport master (
        output i_data, i_wrOut,
        input  o_tx, o_full, o_empty, o_busy, o_overflow
    );

    // Serializer side.
    modport slave (
        input  i_data, i_wrOut,
        output o_tx, o_full, o_empty, o_busy, o_overflow
    );
endinterface

// File: rtl/out_serializer.sv
// Output serializer: a small byte FIFO feeding an 8N1 transmitter.
// Frames go back to back while the queue holds data; o_tx is always a flop.
module out_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              i_clk,
    input  logic              i_nReset,
    out_serializer_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- queue ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count, countNext;
    logic             full, empty, overflow;
    logic             push, pop;
    logic [7:0]       head;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push = bus.i_wrOut & ~full;
    assign head = mem[rdPtr];

    // Occupancy after this edge; drives the registered full/empty flags.
    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    // Pointers, count and status flags; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= countNext;
            full  <= (countNext == CNT_W'(FIFO_DEPTH));
            empty <= (countNext == '0);
            if (bus.i_wrOut && full) overflow <= 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (push) mem[wrPtr] <= bus.i_data;
    end

    // ---------------- transmitter ----------------
    state_t     state, stateNext;
    logic [7:0] bitCnt, bitCntNext;
    logic [2:0] bitIdx, bitIdxNext;
    logic [7:0] shiftReg, shiftNext;
    logic       txReg, txNext;
    logic       busyReg;
    logic       bitDone;

    assign bitDone = (bitCnt == 8'(CLKS_PER_BIT - 1));

    // Next-state, counters, shifter and pop request; o_tx level follows the next state.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt + 8'd1;
        bitIdxNext = bitIdx;
        shiftNext  = shiftReg;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                bitCntNext = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shiftNext  = head;
                    bitIdxNext = '0;
                    stateNext  = START;
                end
            end
            START: begin
                if (bitDone) begin
                    bitCntNext = '0;
                    stateNext  = DATA;
                end
            end
            DATA: begin
                if (bitDone) begin
                    bitCntNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end else begin
                        shiftNext  = {1'b0, shiftReg[7:1]};
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bitDone) begin
                    bitCntNext = '0;
                    if (!empty) begin
                        // Chain straight into the next start bit, no idle cycle.
                        pop        = 1'b1;
                        shiftNext  = head;
                        bitIdxNext = '0;
                        stateNext  = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftNext[0];
            default: txNext = 1'b1;
        endcase
    end

    // Transmitter state register; o_tx and o_busy come straight from flops.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
            busyReg  <= 1'b0;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
            busyReg  <= (stateNext != IDLE);
        end
    end

    assign bus.o_tx       = txReg;
    assign bus.o_busy     = busyReg;
    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_overflow = overflow;
endmodule
